// File: rtl/servo_pwm_gen.sv
// Servo PWM generator. It owns the frame counter, takes clamped width requests over valid/ready
// and applies them only at frame boundaries. Define SERVO_PWM_SLEW_LIMIT_EN to add per-frame slew limiting.
module servo_pwm_gen #(
    parameter int FRAME_TICKS = 20000,
    parameter int CNT_W       = 15,
    parameter int MIN_WIDTH   = 500,
    parameter int MAX_WIDTH   = 2500,
    parameter int RESET_WIDTH = 1500,
    parameter int SLEW_STEP   = 20
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic [11:0]      width_in,
    input  logic             width_valid,
    output logic             width_ready,
    input  logic             enable,
    output logic             pwm_out,
    output logic             frame_start,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [11:0]      width_cur,
    output logic             clamped,
    output logic             busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

`ifdef SERVO_PWM_SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    // Without slew limiting, a step larger than any 12-bit distance makes the limiter transparent.
    localparam int               EFF_STEP = SLEW_EN ? SLEW_STEP : 4096;
    localparam logic [12:0]      STEP     = 13'(EFF_STEP);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_TICKS - 1);
    localparam logic [11:0]      MIN_W    = 12'(MIN_WIDTH);
    localparam logic [11:0]      MAX_W    = 12'(MAX_WIDTH);
    localparam logic [11:0]      RST_W    = 12'(RESET_WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [11:0]      r_width_cur;
    logic [11:0]      r_target;
    logic [11:0]      r_hold;
    logic             r_pending;
    logic             r_clamped;

    logic             w_boundary;
    logic             w_accept;
    logic             w_out_of_range;
    logic [11:0]      w_clamped_in;
    logic [11:0]      w_tgt_eff;
    logic [11:0]      w_step;
    logic [12:0]      w_cur_ext;
    logic [12:0]      w_tgt_ext;
    logic [12:0]      w_up;
    logic [12:0]      w_down;

    assign w_boundary     = (r_frame_cnt == LAST_CNT);
    assign w_accept       = width_valid && !r_pending;
    assign w_out_of_range = (width_in < MIN_W) || (width_in > MAX_W);
    assign w_clamped_in   = (width_in < MIN_W) ? MIN_W :
                            (width_in > MAX_W) ? MAX_W : width_in;
    assign w_tgt_eff      = r_pending ? r_hold : r_target;

    assign w_cur_ext = {1'b0, r_width_cur};
    assign w_tgt_ext = {1'b0, w_tgt_eff};
    assign w_up      = w_cur_ext + STEP;
    assign w_down    = (w_cur_ext > STEP) ? (w_cur_ext - STEP) : 13'd0;

    always_comb begin
        w_step = w_tgt_eff;
        if (w_tgt_ext > w_cur_ext) begin
            if (w_up < w_tgt_ext) w_step = w_up[11:0];
        end else if (w_down > w_tgt_ext) begin
            w_step = w_down[11:0];
        end
    end

    always_ff @(posedge mclk) begin
        if (rst)             r_frame_cnt <= '0;
        else if (w_boundary) r_frame_cnt <= '0;
        else                 r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end

    // An accept on the boundary cycle lands in hold and is not seen until the next boundary.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_width_cur <= RST_W;
            r_target    <= RST_W;
            r_hold      <= '0;
            r_pending   <= 1'b0;
            r_clamped   <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_target    <= w_tgt_eff;
                r_width_cur <= w_step;
            end
            if (w_accept) begin
                r_hold    <= w_clamped_in;
                r_clamped <= w_out_of_range;
            end
            if (w_accept)        r_pending <= 1'b1;
            else if (w_boundary) r_pending <= 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_boundary && enable) w_state_next = ST_RUN;
            ST_RUN:   if (!enable) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_boundary) w_state_next = enable ? ST_RUN : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign pwm_out     = (r_state != ST_IDLE) && (r_frame_cnt < CNT_W'(r_width_cur));
    assign frame_start = (r_frame_cnt == '0);
    assign frame_cnt   = r_frame_cnt;
    assign width_cur   = r_width_cur;
    assign width_ready = ~r_pending;
    assign clamped     = r_clamped;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Downstream stage of the servo position controller; converts a requested pulse width (1 MHz ticks, 0..2200 range from upstream) into the physical servo PWM waveform.
- Owns its own 20 ms frame counter.
- Buffers one pending request via a valid/ready handshake, clamps it to safe servo limits and applies it only at frame boundaries, so pulses are never runted or truncated.
- Optional per-frame slew limiting.

Parameters:
- FRAME_TICKS, 20000, mclk ticks per PWM frame (20 ms at 1 MHz).
- CNT_W, 15, frame counter width.
- MIN_WIDTH, 500, minimum pulse width in ticks; requests below it are clamped.
- MAX_WIDTH, 2500, maximum pulse width in ticks; requests above it are clamped.
- RESET_WIDTH, 1500, pulse width after reset (servo centre).
- SLEW_STEP, 20, maximum width change per frame when slew limiting is compiled in.

Ports:
- mclk  in  1  1 MHz system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- width_in  in  12  requested pulse width in ticks.
- width_valid  in  1  width_in is valid.
- width_ready  out  1  block can accept a request.
- enable  in  1  run request for the PWM output.
- pwm_out  out  1  servo PWM signal.
- frame_start  out  1  high while frame_cnt == 0.
- frame_cnt  out  CNT_W  current frame position, 0..FRAME_TICKS-1.
- width_cur  out  12  pulse width applied in the current frame.
- clamped  out  1  last accepted request was clamped.
- busy  out  1  state is RUN or DRAIN.

Behaviour:
- Reset (rst=1 at posedge) sets:
  - frame_cnt=0, state=IDLE
  - width_cur=target=RESET_WIDTH
  - pending=0, hold=0, clamped=0
  - width_ready=1, pwm_out=0, busy=0
- Reset applies mid-pulse too: pwm_out is low from the cycle after the reset edge.
- Frame counter:
  - Increments every cycle.
  - Wraps FRAME_TICKS-1 -> 0.
  - Runs in every state.
- Boundary cycle is frame_cnt == FRAME_TICKS-1.
- Handshake:
  - width_ready = ~pending.
  - Accept when width_valid && width_ready: hold <= clamp(width_in), pending <= 1, clamped <= (width_in < MIN_WIDTH || width_in > MAX_WIDTH).
  - width_valid while width_ready is low is held off with no side effects.
- Clamp: values below MIN_WIDTH become MIN_WIDTH; values above MAX_WIDTH become MAX_WIDTH; unsigned 12-bit compare. Example: width_in 0 becomes 500.
- At the boundary cycle:
  - tgt_eff = pending ? hold : target.
  - target <= tgt_eff; pending <= 0.
  - width_cur <= step(width_cur, tgt_eff) (see Optional Feature).
  - Width updates occur in every state.
- Simultaneous accept and boundary (possible only when pending=0):
  - The new value is stored in hold with pending=1.
  - The boundary uses the old target.
  - The new value takes effect at the next boundary.
- If a request was pending at the boundary, width_ready is high again from the cycle after the boundary.
- State machine (IDLE, RUN, DRAIN); transitions evaluated at posedge:
  - IDLE: at boundary, if enable=1 go to RUN. Enable asserted mid-frame waits for the boundary, so the first pulse starts exactly at frame_cnt 0.
  - RUN: enable=0 on any cycle goes to DRAIN.
  - DRAIN: at boundary, go to RUN if enable=1, otherwise IDLE. enable=1 mid-frame while in DRAIN does not return to RUN early.
- pwm_out = (state != IDLE) && (frame_cnt < width_cur):
  - Combinational from registers.
  - Pulse is exactly width_cur ticks long.
  - An enable drop mid-pulse never truncates the pulse.
  - No new pulse starts after DRAIN ends in IDLE.
- busy = (state != IDLE).

Optional Feature:
- Macro: SERVO_PWM_SLEW_LIMIT_EN.
- Defined: step moves width_cur toward tgt_eff by at most SLEW_STEP per boundary, without overshoot: min(tgt, cur+SLEW_STEP) when rising, max(tgt, cur-SLEW_STEP) when falling.
- Undefined: width_cur <= tgt_eff directly at the boundary.

Test Plan:
- Reset/start: rst 2 cycles, enable=1 at frame_cnt 300 -> pwm_out low until frame_cnt wraps to 0; then high exactly 1500 ticks per frame, period 20000; width_ready=1.
- Clamp: accept 0 -> clamped=1 and next frame width 500 (macro off); accept 2200 -> clamped=0, width 2200; accept 3000 -> clamped=1, width 2500.
- Slew, macro on, STEP 20: width_cur 1500, accept 1600 -> successive frames 1520, 1540, 1560, 1580, 1600, then constant; accept 1590 afterwards -> 1590 in one frame. Macro off: 1500 -> 1600 in one frame.
- Handshake: width_valid held with 1000 then 1200 back-to-back:
  - First value accepted.
  - width_ready=0 until the cycle after the boundary, then 1200 is accepted.
  - A value accepted on the boundary cycle itself (e.g. 1800) does not change that boundary's width; it applies one frame later.
- Enable drop: width 1500, enable=0 at frame_cnt 700 -> pulse still ends at 1500, busy=1 until the boundary, then IDLE with no pulses; re-enable at frame_cnt 5000 -> first pulse at the next frame_cnt 0.
- Mid-pulse reset: rst at frame_cnt 800 in RUN -> next cycle pwm_out=0, frame_cnt=0, width_cur=1500, IDLE, pending cleared.
